spi_boot_loader: RTL and testbench

//  Sequences the SPI microSD command engine after card init completes. Reads NUM_SECTORS

---
 rtl/spi_boot_loader_pkg.sv | 30 +++
 rtl/spi_byte_packer.sv | 41 ++++
 rtl/spi_boot_loader.sv | 196 +++++++++++++++++++
 tb/tb_spi_boot_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_boot_loader_pkg.sv
// Shared constants, statusreg encodings and loader state enum for the SPI boot loader.
package spi_boot_loader_pkg;

  localparam logic [7:0]  CMD17_OP   = 8'h51;
  localparam logic [7:0]  DATA_TOKEN = 8'hFE;
  localparam logic [7:0]  R1_OK      = 8'h00;
  localparam logic [7:0]  BYTE_IDLE  = 8'hFF;
  localparam logic [47:0] IWAIT      = 48'hFFFF_FFFF_FFFF;

  // div 1:4, rd=1, MSB-first, op=1
  localparam logic [7:0]  STATUS_RD  = 8'b1010_1011;
  localparam logic [7:0]  STATUS_OFF = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_R1WAIT,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  function automatic logic [47:0] cmd17_frame(input logic [31:0] arg);
    return {CMD17_OP, arg, 8'hFF};
  endfunction

endpackage

// File: rtl/spi_byte_packer.sv
// Packs four received bytes big-endian into a 32-bit word with a one-cycle valid strobe.
module spi_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_vld_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (byte_vld_i) begin
        shift_q <= {shift_q[15:0], byte_i};
        cnt_q   <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          word_q <= {shift_q, byte_i};
          vld_q  <= 1'b1;
        end
      end
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = vld_q;

endmodule

// File: rtl/spi_boot_loader.sv
// Reads consecutive sectors with CMD17 through the SPI engine and writes them into boot RAM.
module spi_boot_loader
  import spi_boot_loader_pkg::*;
#(
  parameter logic [31:0] START_SECTOR  = 32'h0000_4200,
  parameter int          NUM_SECTORS   = 16,
  parameter int          ADDR_W        = 12,
  parameter int          R1_TIMEOUT    = 8,
  parameter int          TOKEN_TIMEOUT = 1024,
  parameter int          MAX_RETRY     = 3
) (
  input  logic              spi_clk_i,
  input  logic              spi_rst_i,
  input  logic              spi_initdone_i,
  input  logic              spi_start_i,
  input  logic [2:0]        spi_flagreg_i,
  input  logic [7:0]        spi_rxbyte_i,
  output logic [47:0]       spi_datacmd_o,
  output logic [7:0]        spi_statusreg_o,
  output logic              spi_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              busy_o,
  output logic              boot_done_o,
  output logic              boot_err_o
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  boot_state_e         state_q, state_d;
  logic [31:0]         sector_q, sector_d;
  logic [15:0]         remain_q, remain_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [10:0]         tmo_q, tmo_d;
  logic [8:0]          byte_q, byte_d;
  logic                req_q, req_d;

  logic        rx_vld;
  logic        do_retry;
  logic [10:0] tmo_inc;
  logic [31:0] word;
  logic        word_vld;
  logic        unused_flag;

  assign unused_flag = spi_flagreg_i[2];
  assign rx_vld      = spi_flagreg_i[0];

  spi_byte_packer u_packer (
    .clk_i      (spi_clk_i),
    .rst_i      (spi_rst_i),
    .clear_i    (state_q == ST_CMD),
    .byte_vld_i (rx_vld && (state_q == ST_DATA)),
    .byte_i     (spi_rxbyte_i),
    .word_o     (word),
    .word_vld_o (word_vld)
  );

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state_q  <= ST_IDLE;
      sector_q <= START_SECTOR;
      remain_q <= 16'(NUM_SECTORS);
      retry_q  <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      tmo_q    <= '0;
      byte_q   <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      remain_q <= remain_d;
      retry_q  <= retry_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      tmo_q    <= tmo_d;
      byte_q   <= byte_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    remain_d = remain_q;
    retry_d  = retry_q;
    addr_d   = addr_q;
    base_d   = base_q;
    tmo_d    = tmo_q;
    byte_d   = byte_q;
    req_d    = 1'b0;
    do_retry = 1'b0;
    tmo_inc  = tmo_q + 11'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (spi_start_i && spi_initdone_i) begin
          state_d = ST_CMD;
          req_d   = 1'b1;
        end
      end
      ST_CMD: begin
        if (spi_flagreg_i[1]) begin
          state_d = ST_R1WAIT;
          tmo_d   = '0;
        end
      end
      ST_R1WAIT: begin
        if (rx_vld) begin
          if (spi_rxbyte_i == BYTE_IDLE) begin
            tmo_d = tmo_inc;
            if (tmo_inc == 11'(R1_TIMEOUT)) do_retry = 1'b1;
          end else if (spi_rxbyte_i == R1_OK) begin
            state_d = ST_TOKEN;
            tmo_d   = '0;
          end else begin
            do_retry = 1'b1;
          end
        end
      end
      ST_TOKEN: begin
        if (rx_vld) begin
          if (spi_rxbyte_i == BYTE_IDLE) begin
            tmo_d = tmo_inc;
            if (tmo_inc == 11'(TOKEN_TIMEOUT)) do_retry = 1'b1;
          end else if (spi_rxbyte_i == DATA_TOKEN) begin
            state_d = ST_DATA;
            byte_d  = '0;
          end else begin
            do_retry = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (rx_vld) begin
          if (byte_q == 9'd511) begin
            state_d = ST_CRC;
            byte_d  = '0;
          end else begin
            byte_d = byte_q + 9'd1;
          end
        end
      end
      ST_CRC: begin
        if (rx_vld) begin
          if (byte_q == 9'd1) state_d = ST_NEXT;
          else                byte_d  = byte_q + 9'd1;
        end
      end
      ST_NEXT: begin
        // the last word of the sector was written in the first CRC cycle, so addr_q is the next base
        sector_d = sector_q + 32'd1;
        remain_d = remain_q - 16'd1;
        retry_d  = '0;
        base_d   = addr_q;
        if (remain_q == 16'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CMD;
          req_d   = 1'b1;
        end
      end
      default: ;
    endcase

    if (word_vld) addr_d = addr_q + 1'b1;

    if (do_retry) begin
      if (retry_q == RETRY_W'(MAX_RETRY)) begin
        state_d = ST_ERR;
      end else begin
        retry_d = retry_q + 1'b1;
        addr_d  = base_q;
        state_d = ST_CMD;
        req_d   = 1'b1;
      end
    end
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  end

  assign spi_datacmd_o   = busy_o ? cmd17_frame(sector_q) : IWAIT;
  assign spi_statusreg_o = busy_o ? STATUS_RD : STATUS_OFF;
  assign spi_req_o       = req_q;
  assign mem_we_o        = word_vld;
  assign mem_addr_o      = addr_q;
  assign mem_data_o      = word;
  assign boot_done_o     = (state_q == ST_DONE);
  assign boot_err_o      = (state_q == ST_ERR);

endmodule

// File: tb/tb_spi_boot_loader.sv
// Randomized bench for spi_boot_loader: a card model answers each CMD17 and a scoreboard checks RAM writes.
module tb_spi_boot_loader;

  localparam logic [31:0] START = 32'h0000_4200;
  localparam int NS  = 3;
  localparam int AW  = 12;
  localparam int R1T = 8;
  localparam int TKT = 1024;
  localparam int MR  = 3;

  typedef enum int {K_OK, K_R1BAD, K_R1TMO, K_TOKBAD, K_TOKTMO} kind_e;

  logic          clk, rst, initdone, start;
  logic [2:0]    flag;
  logic [7:0]    rxb;
  logic [47:0]   datacmd;
  logic [7:0]    statusreg;
  logic          req, we, busy, done, err;
  logic [AW-1:0] addr;
  logic [31:0]   data;

  spi_boot_loader #(
    .START_SECTOR(START), .NUM_SECTORS(NS), .ADDR_W(AW),
    .R1_TIMEOUT(R1T), .TOKEN_TIMEOUT(TKT), .MAX_RETRY(MR)
  ) dut (
    .spi_clk_i(clk), .spi_rst_i(rst), .spi_initdone_i(initdone), .spi_start_i(start),
    .spi_flagreg_i(flag), .spi_rxbyte_i(rxb), .spi_datacmd_o(datacmd),
    .spi_statusreg_o(statusreg), .spi_req_o(req), .mem_we_o(we), .mem_addr_o(addr),
    .mem_data_o(data), .busy_o(busy), .boot_done_o(done), .boot_err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0]   got_frames[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  int            nwrites;
  logic [31:0]   first_data;
  logic [AW-1:0] first_addr, last_addr;
  logic [AW-1:0] mon_ea;
  logic [31:0]   mon_ed;

  // card-side model: sector index being loaded, retries used on it, expected end state
  int m_idx, m_retry;
  bit m_err, m_done;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req) got_frames.push_back(datacmd);
      if (we) begin
        if (nwrites == 0) begin
          first_data = data;
          first_addr = addr;
        end
        last_addr = addr;
        nwrites++;
        if (exp_addr.size() == 0) begin
          check("unexpected_write", 64'(addr), 64'hFFFF_FFFF);
        end else begin
          mon_ea = exp_addr.pop_front();
          mon_ed = exp_data.pop_front();
          check("wr_addr", 64'(addr), 64'(mon_ea));
          check("wr_data", 64'(data), 64'(mon_ed));
        end
      end
      if (busy) begin
        check("status_busy", 64'(statusreg), 64'hAB);
        check("frame_opcode", 64'(datacmd[47:40]), 64'h51);
      end else begin
        check("status_idle", 64'(statusreg), 64'h00);
        check("frame_iwait", 64'(datacmd), 64'hFFFF_FFFF_FFFF);
      end
      check("done_err_excl", 64'(done & err), 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) tick();
    flag[0] = 1'b1;
    rxb     = b;
    tick();
    flag[0] = 1'b0;
    rxb     = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},     64'(we),        64'h0);
    check({tag, "_req"},    64'(req),       64'h0);
    check({tag, "_busy"},   64'(busy),      64'h0);
    check({tag, "_done"},   64'(done),      64'h0);
    check({tag, "_err"},    64'(err),       64'h0);
    check({tag, "_addr"},   64'(addr),      64'h0);
    check({tag, "_data"},   64'(data),      64'h0);
    check({tag, "_cmd"},    64'(datacmd),   64'hFFFF_FFFF_FFFF);
    check({tag, "_status"}, 64'(statusreg), 64'h00);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flag  = '0;
    start = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    got_frames.delete();
    exp_addr.delete();
    exp_data.delete();
    nwrites = 0;
    m_idx   = 0;
    m_retry = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    tick();
  endtask

  // Plays one CMD17 transaction from the card side; cut < 512 stops after that many data bytes.
  task automatic run_attempt(input kind_e k, input bit fixed, input int cut);
    logic [47:0] f;
    logic [7:0]  d [512];
    int waited;
    waited = 0;
    while (got_frames.size() == 0 && waited < 200) begin
      tick();
      waited++;
    end
    if (got_frames.size() == 0) begin
      check("req_timeout", 64'h0, 64'h1);
      return;
    end
    f = got_frames.pop_front();
    check("cmd_frame", 64'(f), 64'({8'h51, START + 32'(m_idx), 8'hFF}));
    repeat (2) tick();
    flag[1] = 1'b1;
    tick();
    flag[1] = 1'b0;
    case (k)
      K_OK: begin
        for (int i = 0; i < 512; i++) d[i] = fixed ? 8'(i) : 8'($urandom);
        for (int w = 0; w < 128; w++) begin
          exp_addr.push_back(AW'(m_idx * 128 + w));
          exp_data.push_back({d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]});
        end
        repeat ($urandom_range(0, R1T - 2)) send_byte(8'hFF);
        send_byte(8'h00);
        repeat ($urandom_range(0, 8)) send_byte(8'hFF);
        send_byte(8'hFE);
        for (int i = 0; i < 512; i++) begin
          if (i == cut) return;
          send_byte(d[i]);
        end
        send_byte(8'($urandom));
        send_byte(8'($urandom));
      end
      K_R1BAD: begin
        repeat ($urandom_range(0, 3)) send_byte(8'hFF);
        send_byte(8'($urandom_range(1, 254)));
      end
      K_R1TMO: repeat (R1T) send_byte(8'hFF);
      K_TOKBAD: begin
        send_byte(8'h00);
        repeat ($urandom_range(0, 4)) send_byte(8'hFF);
        send_byte(8'h08);
      end
      default: begin
        send_byte(8'h00);
        repeat (TKT) send_byte(8'hFF);
      end
    endcase
    if (k == K_OK) begin
      m_idx++;
      m_retry = 0;
      if (m_idx == NS) m_done = 1'b1;
    end else if (m_retry == MR) begin
      m_err = 1'b1;
    end else begin
      m_retry++;
    end
  endtask

  task automatic wait_end(input string name);
    int waited;
    waited = 0;
    while (!done && !err && waited < 100) begin
      tick();
      waited++;
    end
    check({name, "_done"}, 64'(done), 64'(m_done));
    check({name, "_err"},  64'(err),  64'(m_err));
    check({name, "_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    initdone = 1'b0;
    start    = 1'b0;
    flag     = '0;
    rxb      = '0;
    nwrites  = 0;
    do_reset();

    // start without card init must be ignored
    pulse_start();
    repeat (20) tick();
    check("no_req_wo_initdone", 64'(got_frames.size()), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);

    // full load with a token error and an R1 error along the way
    initdone = 1'b1;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'h1);
    run_attempt(K_OK, 1'b1, 512);
    initdone = 1'b0;
    run_attempt(K_TOKBAD, 1'b0, 512);
    run_attempt(K_OK, 1'b0, 512);
    run_attempt(K_R1BAD, 1'b0, 512);
    run_attempt(K_OK, 1'b0, 512);
    wait_end("load");
    check("load_done_lit", 64'(done), 64'h1);
    check("load_writes", 64'(nwrites), 64'(NS * 128));
    check("load_pending", 64'(exp_addr.size()), 64'h0);
    check("first_word", 64'(first_data), 64'h0001_0203);
    check("first_addr", 64'(first_addr), 64'h0);
    check("last_addr", 64'(last_addr), 64'd383);
    initdone = 1'b1;
    pulse_start();
    repeat (20) tick();
    check("done_ignores_start", 64'(got_frames.size()), 64'h0);
    check("done_sticky", 64'(done), 64'h1);

    // retry budget exhausted on sector 0
    do_reset();
    pulse_start();
    run_attempt(K_R1TMO, 1'b0, 512);
    run_attempt(K_TOKTMO, 1'b0, 512);
    run_attempt(K_R1BAD, 1'b0, 512);
    run_attempt(K_R1TMO, 1'b0, 512);
    wait_end("retry_out");
    check("err_lit", 64'(err), 64'h1);
    check("err_no_writes", 64'(nwrites), 64'h0);
    pulse_start();
    repeat (20) tick();
    check("err_no_more_req", 64'(got_frames.size()), 64'h0);

    // reset lands on the cycle of the write that follows data byte 300
    do_reset();
    pulse_start();
    run_attempt(K_OK, 1'b0, 300);
    check("we_at_byte300", 64'(we), 64'h1);
    check("addr_at_byte300", 64'(addr), 64'd74);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
